// File: rtl/fast_event_counter_pkg.sv
// Shared types and helpers for fast_event_counter: default sizes, saturating add, report payload.
package fast_event_counter_pkg;

  localparam int unsigned DEFAULT_WINDOW = 16;
  localparam int unsigned DEFAULT_CNT_W  = 8;
  // Widest count the helpers carry; instances use CNT_W <= SAT_MAX_W.
  localparam int unsigned SAT_MAX_W      = 32;
  localparam int unsigned SAT_EXT_W      = SAT_MAX_W + 1;

  typedef struct packed {
    logic [SAT_MAX_W-1:0] sum;
    logic                 ovf;
  } sat_sum_t;

  typedef struct packed {
    logic [SAT_MAX_W-1:0] count;
    logic                 overrun;
    logic                 sat;
  } report_t;

  // a + b clamped to 2^w-1; ovf flags that the clamp was applied.
  function automatic sat_sum_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                       input logic [SAT_MAX_W-1:0] b,
                                       input int unsigned          w);
    logic [SAT_EXT_W-1:0] full;
    logic [SAT_EXT_W-1:0] lim;
    sat_sum_t             r;
    full  = {1'b0, a} + {1'b0, b};
    lim   = (SAT_EXT_W'(1) << w) - SAT_EXT_W'(1);
    r.ovf = (full > lim);
    r.sum = r.ovf ? lim[SAT_MAX_W-1:0] : full[SAT_MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fast_event_counter_rise_detect.sv
// Rising-edge detector for the synchronized strobe; emits a one-cycle edge gated by en.
// FAST_EVENT_COUNTER_GLITCH_FILTER_EN: require two consecutive high samples after a low.
module fast_rise_detect
  import fast_event_counter_pkg::*;
(
  input  logic fclk,
  input  logic reset,
  input  logic ev_in,
  input  logic en,
  output logic ev_edge_c
);

  logic ev_prev;

`ifdef FAST_EVENT_COUNTER_GLITCH_FILTER_EN
  logic ev_prev2;

  // History resets high so a strobe already asserted at reset exit is not an edge.
  always_ff @(posedge fclk) begin
    if (reset) begin
      ev_prev  <= 1'b1;
      ev_prev2 <= 1'b1;
    end else begin
      ev_prev  <= ev_in;
      ev_prev2 <= ev_prev;
    end
  end

  assign ev_edge_c = en & ev_in & ev_prev & ~ev_prev2;
`else
  always_ff @(posedge fclk) begin
    if (reset) begin
      ev_prev <= 1'b1;
    end else begin
      ev_prev <= ev_in;
    end
  end

  assign ev_edge_c = en & ev_in & ~ev_prev;
`endif

endmodule

// File: rtl/fast_event_counter.sv
// Counts strobe edges per WINDOW enabled fclk cycles and reports each window over valid/ready.
// FAST_EVENT_COUNTER_GLITCH_FILTER_EN selects the two-sample edge filter in fast_rise_detect.
module fast_event_counter
  import fast_event_counter_pkg::*;
#(
  parameter int unsigned WINDOW = DEFAULT_WINDOW,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
  input  logic             fclk,
  input  logic             reset,
  input  logic             ev_in,
  input  logic             en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_count,
  output logic             m_overrun,
  output logic             m_sat
);

  localparam int unsigned      WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  logic             ev_edge_c;
  logic             close_c;
  logic             res_sat;
  sat_sum_t         acc_add;
  sat_sum_t         merge;

  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_d;
  logic             acc_sat_q;
  logic             acc_sat_d;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_d;
  report_t          rep_q;
  report_t          rep_d;
  logic             valid_d;

  fast_rise_detect u_rise (
    .fclk      (fclk),
    .reset     (reset),
    .ev_in     (ev_in),
    .en        (en),
    .ev_edge_c (ev_edge_c)
  );

  always_ff @(posedge fclk) begin
    if (reset) begin
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
      win_q     <= '0;
      rep_q     <= '0;
      m_valid   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
      win_q     <= win_d;
      rep_q     <= rep_d;
      m_valid   <= valid_d;
    end
  end

  // Window/accumulator advance and report load; a stalled report absorbs new windows.
  always_comb begin
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    win_d     = win_q;
    rep_d     = rep_q;
    valid_d   = m_valid;

    acc_add = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(ev_edge_c), CNT_W);
    merge   = sat_add(rep_q.count, acc_add.sum, CNT_W);
    res_sat = acc_sat_q | acc_add.ovf;
    close_c = en & (win_q == WIN_LAST);

    if (en) begin
      if (close_c) begin
        acc_d     = '0;
        acc_sat_d = 1'b0;
        win_d     = '0;
      end else begin
        acc_d     = CNT_W'(acc_add.sum);
        acc_sat_d = res_sat;
        win_d     = win_q + WIN_W'(1);
      end
    end

    if (close_c) begin
      valid_d = 1'b1;
      if (!m_valid || m_ready) begin
        rep_d.count   = acc_add.sum;
        rep_d.overrun = 1'b0;
        rep_d.sat     = res_sat;
      end else begin
        rep_d.count   = merge.sum;
        rep_d.overrun = 1'b1;
        rep_d.sat     = rep_q.sat | res_sat | merge.ovf;
      end
    end else if (m_valid && m_ready) begin
      valid_d = 1'b0;
    end
  end

  assign m_count   = CNT_W'(rep_q.count);
  assign m_overrun = rep_q.overrun;
  assign m_sat     = rep_q.sat;

endmodule
